// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode-side signal bundle of the fetch unit
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;

  modport master (
    output imem_addr,
    input  imem_instr,
    output id_instr,
    output id_pc4,
    output id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  id_instr,
    input  id_pc4,
    input  id_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and fetch front end; stall refetch, redirect restart.
// Optional FETCH_PERF_CNT_EN adds perf_fetch/perf_stall/perf_redirect counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_unit_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_redirect
`endif
);

  localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] pc;
  logic [31:0] f2_pc;
  logic        f2_valid;
  logic [31:0] target;

  assign target = redirect_pc & 32'hFFFF_FFFC;

  // Stalling re-presents f2_pc so the memory output stays on the held instruction.
  always_comb begin
    fif.imem_addr = pc;
    if (redirect) begin
      fif.imem_addr = target;
    end else if (stall) begin
      fif.imem_addr = f2_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_ADDR;
      f2_pc    <= RESET_ADDR;
      f2_valid <= 1'b0;
    end else if (redirect) begin
      f2_pc    <= target;
      pc       <= target + 32'd4;
      f2_valid <= 1'b1;
    end else if (!stall) begin
      f2_pc    <= pc;
      pc       <= pc + 32'd4;
      f2_valid <= 1'b1;
    end
  end

  assign fif.id_instr = f2_valid ? fif.imem_instr : 32'h0000_0000;
  assign fif.id_pc4   = f2_pc + 32'd4;
  assign fif.id_valid = f2_valid;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch    <= 32'd0;
      perf_stall    <= 32'd0;
      perf_redirect <= 32'd0;
    end else begin
      if (redirect || !stall) begin
        perf_fetch <= perf_fetch + 32'd1;
      end
      if (stall && !redirect) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (redirect) begin
        perf_redirect <= perf_redirect + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a presented-PC reference model
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_unit_if fif ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_redirect;
`endif

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .fif(fif)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch(perf_fetch),
    .perf_stall(perf_stall),
    .perf_redirect(perf_redirect)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous instruction memory: word i holds 32'h1000_0000 + i.
  always @(posedge clk) fif.imem_instr <= mem_word(fif.imem_addr);

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] p_fetch;
    logic [31:0] p_stall;
    logic [31:0] p_redir;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the PC currently presented to decode and whether it is real.
  logic [31:0] m_pc = RESET_PC;
  logic        m_valid = 1'b0;
  logic [31:0] m_fetch = 0, m_stall = 0, m_redir = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_valid = 1'b0;
    m_fetch = 0;
    m_stall = 0;
    m_redir = 0;
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    logic [31:0] tgt, nxt, exp_addr;
    exp_t e;
    @(negedge clk);
    stall = s;
    redirect = r;
    redirect_pc = t;
    #1;
    tgt = {t[31:2], 2'b00};
    nxt = m_valid ? m_pc + 32'd4 : RESET_PC;
    exp_addr = r ? tgt : (s ? m_pc : nxt);
    check("imem_addr", fif.imem_addr, exp_addr);
    if (rst_n) begin
      if (r) begin
        m_pc = tgt; m_valid = 1'b1; m_redir++; m_fetch++;
      end else if (s) begin
        m_stall++;
      end else begin
        m_pc = nxt; m_valid = 1'b1; m_fetch++;
      end
    end
    e.valid   = m_valid;
    e.instr   = m_valid ? mem_word(m_pc) : 32'h0;
    e.pc4     = m_pc + 32'd4;
    e.p_fetch = m_fetch;
    e.p_stall = m_stall;
    e.p_redir = m_redir;
    sb_q.push_back(e);
  endtask

  task automatic async_reset_check();
    check("rst_id_valid", {31'b0, fif.id_valid}, 32'd0);
    check("rst_id_instr", fif.id_instr, 32'h0);
    check("rst_id_pc4", fif.id_pc4, RESET_PC + 32'd4);
    check("rst_imem_addr", fif.imem_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch, 32'd0);
    check("rst_perf_stall", perf_stall, 32'd0);
    check("rst_perf_redirect", perf_redirect, 32'd0);
`endif
  endtask

  // Monitor: every entry pushed at a falling edge is due just after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("id_valid", {31'b0, fif.id_valid}, {31'b0, e.valid});
        check("id_instr", fif.id_instr, e.instr);
        check("id_pc4", fif.id_pc4, e.pc4);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", perf_fetch, e.p_fetch);
        check("perf_stall", perf_stall, e.p_stall);
        check("perf_redirect", perf_redirect, e.p_redir);
`endif
      end
    end
  end

  initial begin
    #1;
    async_reset_check();
    step(1'b0, 1'b0, 32'h0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Free run, then a 3-cycle stall while memory[2] is presented.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0);

    // Redirect to an unaligned target, alone and combined with stall.
    step(1'b0, 1'b1, 32'h0000_0004);
    step(1'b0, 1'b1, 32'h0000_0023);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0004);
    step(1'b1, 1'b1, 32'h0000_0023);
    step(1'b0, 1'b0, 32'h0);

    // Wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (2) step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
    end

    // Asynchronous reset mid-stream, then the counter scenario.
    @(posedge clk); #3;
    stall = 1'b0; redirect = 1'b0; rst_n = 1'b0;
    #1;
    model_reset();
    async_reset_check();
    step(1'b0, 1'b0, 32'h0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0100);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    @(posedge clk); #2;
`ifdef FETCH_PERF_CNT_EN
    check("plan_perf_stall", perf_stall, 32'd2);
    check("plan_perf_redirect", perf_redirect, 32'd1);
    check("plan_perf_fetch", perf_fetch, 32'd6);
`endif
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the pipeline: owns the program counter, drives the word address into the instruction memory, and tags the instruction that memory returns one clock later with its PC+4 and a valid bit for the decode stage. It sits directly upstream of the synchronous instruction memory, whose output is registered on the rising clock edge, and directly feeds IF/ID decode. It handles decode-stage stalls by refetching, and handles taken-branch/jump redirects from later stages.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- stall  input  1  decode cannot accept; hold current instruction
- redirect  input  1  taken branch/jump resolved; restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_addr  output  32  byte address to instruction memory (combinational)
- imem_instr  input  32  instruction memory read data, for address sampled at previous edge
- id_instr  output  32  instruction to decode; 32'h0 (NOP) when id_valid=0
- id_pc4  output  32  PC+4 of id_instr
- id_valid  output  1  id_instr is a real fetched instruction

## Operation
- State: pc (next address to fetch), f2_pc (address whose data is on imem_instr), f2_valid.
- imem_addr mux, priority order: redirect -> {redirect_pc[31:2],2'b00}; else stall -> f2_pc; else pc. Bits [1:0] always 0.
- Edge update, priority order:
  - redirect: f2_pc <= {redirect_pc[31:2],2'b00}; pc <= that+4; f2_valid <= 1.
  - stall (no redirect): pc, f2_pc, f2_valid hold; memory refetches f2_pc so imem_instr is unchanged.
  - normal: f2_pc <= pc; pc <= pc+4; f2_valid <= 1.
- Outputs: id_instr = f2_valid ? imem_instr : 32'h0; id_pc4 = f2_pc+4; id_valid = f2_valid.
- Redirect overrides stall in the same cycle; the instruction currently presented is wrong-path and is replaced at the edge, so no separate squash is needed in this block. Squashing decode/execute registers is the consumer's job.
- Arithmetic is 32-bit modulo: PC 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. Same for id_pc4.

## Timing
- Reset (asserted, asynchronous): pc = RESET_PC, f2_pc = RESET_PC, f2_valid = 0. Resulting outputs: id_valid = 0, id_instr = 0, id_pc4 = RESET_PC+4, imem_addr = RESET_PC (when no redirect/stall).
- First rising edge after rst_n rises: memory samples RESET_PC. id_valid = 1 with instr@RESET_PC from that cycle on.
- Fetch latency: 1 cycle from imem_addr sampled to id_instr valid. Throughput is 1 instruction per cycle when not stalled.
- Stall for N cycles: id_instr/id_pc4 are held for N+1 cycles total. The next instruction appears on the cycle after stall deasserts.
- Redirect sampled at edge k: the redirect target is on id_instr in cycle k+1, and target+4 is on id_instr in cycle k+2.
- Reset mid-operation: asynchronous return to reset state. Any in-flight instruction is dropped (id_valid = 0 immediately).
- imem_instr is only meaningful after the memory's output delay. Consumers sample id_* at the next rising edge only.

## Configuration
- FETCH_PERF_CNT_EN defined: adds three outputs:
  - perf_fetch  32 bits: +1 on each edge where the normal or redirect path is taken.
  - perf_stall  32 bits: +1 on each edge with stall=1 and redirect=0.
  - perf_redirect  32 bits: +1 on each edge with redirect=1.
  - All three reset to 0 and wrap at 2^32.
- FETCH_PERF_CNT_EN undefined: counters and ports are absent. Fetch behaviour is identical.

## Test plan
- Reset then free-run, memory[i] = 32'h1000_0000+i, RESET_PC=0:
  - Cycle 1 after release: id_valid=1, id_instr=32'h1000_0000, id_pc4=4.
  - Each subsequent cycle steps +1 instruction, +4 pc4.
- Stall held 3 cycles while id_pc4=12: id_instr=memory[2] for 4 cycles. Next cycle shows memory[3], id_pc4=16. No skipped or duplicated words.
- Redirect to 32'h0000_0023 at the edge where id_pc4=8: next cycle id_pc4=32'h24 with memory[8]; following cycle id_pc4=32'h28.
- Redirect and stall asserted together: redirect wins, identical result to the previous case.
- Redirect to 32'hFFFF_FFFC: id_pc4=0 that cycle, then pc wraps; next fetch address is 32'h0000_0000.
- rst_n dropped mid-stream: id_valid=0 and imem_addr=RESET_PC asynchronously. With FETCH_PERF_CNT_EN, counters=0. After stall 2 + redirect 1 + 5 free cycles: perf_stall=2, perf_redirect=1, perf_fetch=6.
